// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the Execute stage.
// One shift-add (MUL*) or restoring (DIV*/REM*) step per cycle on operand
// magnitudes, sign fix-up on the last step, and a one-cycle result pulse.
// Ports:
//   clk, reset       clock (rising edge), synchronous active-low reset
//   FlushE           kills any in-flight op; wins over a same-cycle StartE
//   StartE, FunctE   valid M-op in EX and its funct3
//   SrcAE, SrcBE     forwarded rs1/rs2 operands, latched at start
//   RdE              destination register, latched at start
//   BusyE            combinational stall request to the hazard unit
//   DoneE            one-cycle result-valid pulse
//   ResultE, RdOutE  result and destination register, zero unless DoneE
module ex_muldiv_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            FlushE,
  input  logic            StartE,
  input  logic [2:0]      FunctE,
  input  logic [XLEN-1:0] SrcAE,
  input  logic [XLEN-1:0] SrcBE,
  input  logic [4:0]      RdE,
  output logic            BusyE,
  output logic            DoneE,
  output logic [XLEN-1:0] ResultE,
  output logic [4:0]      RdOutE
);

  localparam int unsigned CW = $clog2(XLEN) + 1;
  localparam int unsigned PW = 2 * XLEN;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2, DONE = 2'd3} state_t;

  state_t          state, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   acc_q, acc_d;    // MUL: {partial hi, multiplier}; DIV: {remainder, quotient}
  logic [XLEN-1:0] opnd_q, opnd_d;  // multiplicand or divisor magnitude
  logic [1:0]      fsel_q, fsel_d;
  logic [4:0]      rd_q, rd_d;
  logic            neg_q, neg_d;    // product/quotient negate
  logic            sa_q, sa_d;      // dividend sign, for remainder
  logic            done_q, done_d;
  logic [XLEN-1:0] res_q, res_d;
  logic [4:0]      rdo_q, rdo_d;

  logic [XLEN:0]   add_sum, div_trial;
  logic [PW-1:0]   mul_step, prod_fix;
  logic [XLEN-1:0] quo_step, rem_step, quo_fix, rem_fix;
  logic            div_ge;
  logic            sa_in, sb_in, div_zero, div_ovf;
  logic [XLEN-1:0] mag_a, mag_b;

  // One iteration step of each algorithm plus final sign fix-up.
  always_comb begin
    add_sum   = {1'b0, acc_q[PW-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_step  = {add_sum, acc_q[XLEN-1:1]};
    // Bit XLEN of the trial difference is the borrow: clear means remainder >= divisor.
    div_trial = {acc_q[PW-1:XLEN], acc_q[XLEN-1]} - {1'b0, opnd_q};
    div_ge    = ~div_trial[XLEN];
    rem_step  = div_ge ? div_trial[XLEN-1:0] : {acc_q[PW-2:XLEN], acc_q[XLEN-1]};
    quo_step  = {acc_q[XLEN-2:0], div_ge};
    prod_fix  = neg_q ? -mul_step : mul_step;
    quo_fix   = neg_q ? -quo_step : quo_step;
    rem_fix   = sa_q  ? -rem_step : rem_step;
  end

  // Operand signedness by funct3 and special-case divide detection.
  always_comb begin
    sa_in    = SrcAE[XLEN-1] & (FunctE[2] ? ~FunctE[0]
                                          : (FunctE[1:0] == 2'b01 || FunctE[1:0] == 2'b10));
    sb_in    = SrcBE[XLEN-1] & (FunctE[2] ? ~FunctE[0] : (FunctE[1:0] == 2'b01));
    mag_a    = sa_in ? -SrcAE : SrcAE;
    mag_b    = sb_in ? -SrcBE : SrcBE;
    div_zero = (SrcBE == '0);
    div_ovf  = ~FunctE[0] & (SrcAE == MIN_NEG) & (SrcBE == '1);
  end

  // Next-state and datapath control.
  always_comb begin
    state_d = state;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    fsel_d  = fsel_q;
    rd_d    = rd_q;
    neg_d   = neg_q;
    sa_d    = sa_q;
    done_d  = 1'b0;
    res_d   = '0;
    rdo_d   = '0;
    case (state)
      IDLE: begin
        if (StartE && !FlushE) begin
          fsel_d = FunctE[1:0];
          rd_d   = RdE;
          sa_d   = sa_in;
          neg_d  = sa_in ^ sb_in;
          cnt_d  = '0;
          if (!FunctE[2]) begin
            state_d = MUL;
            acc_d   = {XLEN'(0), mag_b};
            opnd_d  = mag_a;
          end else if (div_zero || div_ovf) begin
            state_d = DONE;
            done_d  = 1'b1;
            rdo_d   = RdE;
            if (FunctE[1]) res_d = div_zero ? SrcAE : '0;
            else           res_d = div_zero ? '1 : MIN_NEG;
          end else begin
            state_d = DIV;
            acc_d   = {XLEN'(0), mag_a};
            opnd_d  = mag_b;
          end
        end
      end
      MUL: begin
        acc_d = mul_step;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(XLEN - 1)) begin
          state_d = DONE;
          done_d  = 1'b1;
          rdo_d   = rd_q;
          res_d   = (fsel_q == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[PW-1:XLEN];
        end
      end
      DIV: begin
        acc_d = {rem_step, quo_step};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(XLEN - 1)) begin
          state_d = DONE;
          done_d  = 1'b1;
          rdo_d   = rd_q;
          res_d   = fsel_q[1] ? rem_fix : quo_fix;
        end
      end
      DONE: state_d = IDLE;  // StartE ignored: ID/EX still holds the finished op
      default: state_d = IDLE;
    endcase
    if (FlushE) begin
      state_d = IDLE;
      done_d  = 1'b0;
      res_d   = '0;
      rdo_d   = '0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= IDLE;
      cnt_q  <= '0;
      acc_q  <= '0;
      opnd_q <= '0;
      fsel_q <= '0;
      rd_q   <= '0;
      neg_q  <= 1'b0;
      sa_q   <= 1'b0;
      done_q <= 1'b0;
      res_q  <= '0;
      rdo_q  <= '0;
    end else begin
      state  <= state_d;
      cnt_q  <= cnt_d;
      acc_q  <= acc_d;
      opnd_q <= opnd_d;
      fsel_q <= fsel_d;
      rd_q   <= rd_d;
      neg_q  <= neg_d;
      sa_q   <= sa_d;
      done_q <= done_d;
      res_q  <= res_d;
      rdo_q  <= rdo_d;
    end
  end

  // Stall starts in the start cycle itself; released in DONE.
  assign BusyE   = (state == MUL) || (state == DIV) || ((state == IDLE) && StartE && !FlushE);
  assign DoneE   = done_q;
  assign ResultE = res_q;
  assign RdOutE  = rdo_q;

endmodule
